// File: rtl/float32_div_seq.sv
// Iterative IEEE-754 single-precision divider: one restoring quotient bit per cycle.
// Truncating rounding, denormals read as zero, and every operation has the same latency.
module float32_div_seq #(
  parameter int unsigned BITWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] c
);

  typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;
  typedef enum logic [1:0] {ClsNorm, ClsNan, ClsInf, ClsZero} cls_e;

  state_e        state_q, state_d;
  cls_e          cls_q, cls_in;
  logic [4:0]    cnt_q;
  logic          sign_q;
  logic [7:0]    ea_q, eb_q;
  logic [23:0]   mb_q;
  logic [24:0]   rem_q, quo_q;
  logic [31:0]   c_q;

  logic          accept;
  logic          a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic          step_ge;
  logic [24:0]   rem_sub, rem_step;
  logic          adj;
  logic [22:0]   frac;
  logic signed [9:0] exp_s;
  logic [31:0]   packed_c;

  assign accept = in_valid & in_ready;
  assign c      = c_q;

  // Operand classification; exp==0 covers both true zero and denormals.
  always_comb begin
    a_zero = (a[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_zero = (b[30:23] == 8'h00);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    cls_in = ClsNorm;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      cls_in = ClsNan;
    end else if (a_inf || b_zero) begin
      cls_in = ClsInf;
    end else if (a_zero || b_inf) begin
      cls_in = ClsZero;
    end
  end

  // One restoring step: compare before shifting so 25 steps yield floor(ma*2^24/mb).
  always_comb begin
    step_ge  = (rem_q >= {1'b0, mb_q});
    rem_sub  = step_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_step = rem_sub << 1;
  end

  always_comb begin
    adj   = ~quo_q[24];
    frac  = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
    exp_s = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127
            - $signed({9'd0, adj});
    packed_c = {sign_q, 31'h0};
    unique case (cls_q)
      ClsNan:  packed_c = 32'h7FC00000;
      ClsInf:  packed_c = {sign_q, 8'hFF, 23'h0};
      ClsZero: packed_c = {sign_q, 31'h0};
      ClsNorm: begin
        if (exp_s >= 10'sd255) begin
          packed_c = {sign_q, 8'hFF, 23'h0};
        end else if (exp_s <= 10'sd0) begin
          packed_c = {sign_q, 31'h0};
        end else begin
          packed_c = {sign_q, exp_s[7:0], frac};
        end
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StDiv;
      end
      StDiv: begin
        if (cnt_q == 5'd24) state_d = StNorm;
      end
      StNorm: state_d = StDone;
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cls_q   <= ClsNorm;
      cnt_q   <= 5'd0;
      sign_q  <= 1'b0;
      ea_q    <= 8'h0;
      eb_q    <= 8'h0;
      mb_q    <= 24'h0;
      rem_q   <= 25'h0;
      quo_q   <= 25'h0;
      c_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            sign_q <= a[31] ^ b[31];
            ea_q   <= a[30:23];
            eb_q   <= b[30:23];
            mb_q   <= {1'b1, b[22:0]};
            rem_q  <= {2'b01, a[22:0]};
            quo_q  <= 25'h0;
            cls_q  <= cls_in;
            cnt_q  <= 5'd0;
          end
        end
        StDiv: begin
          rem_q <= rem_step;
          quo_q <= {quo_q[23:0], step_ge};
          cnt_q <= cnt_q + 5'd1;
        end
        StNorm: c_q <= packed_c;
        StDone: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float32_div_seq.sv
// Self-checking bench for float32_div_seq: expected results are queued at the accepting
// edge and compared when out_valid appears.
module tb_float32_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  float32_div_seq #(.BITWIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  // Reference quotient computed with plain integer division.
  function automatic logic [31:0] model_div(input logic [31:0] x, input logic [31:0] y);
    logic s;
    bit xz, xi, xn, yz, yi, yn;
    longint unsigned num, den, q;
    int e;
    logic [22:0] fr;
    s  = x[31] ^ y[31];
    xz = (x[30:23] == 8'h00);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    yz = (y[30:23] == 8'h00);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
    if (xn || yn || (xz && yz) || (xi && yi)) return 32'h7FC00000;
    if (xi || yz) return {s, 8'hFF, 23'h0};
    if (xz || yi) return {s, 31'h0};
    num = longint'({1'b1, x[22:0]}) << 24;
    den = longint'({1'b1, y[22:0]});
    q   = num / den;
    e   = int'(x[30:23]) - int'(y[30:23]) + 127;
    if (q >= 64'd16777216) begin
      fr = q[23:1];
    end else begin
      fr = q[22:0];
      e  = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], fr};
  endfunction

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hxxxxxxxx;
    return exp_q.pop_front();
  endfunction

  // Waits (bounded) for in_ready, presents one operand pair, queues the expectation on accept.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] expv,
                      output bit to);
    int n = 0;
    to = 1'b0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) begin
      to = 1'b1;
      return;
    end
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(expv);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_valid, bounded.
  task automatic wait_result(output logic [31:0] cv, output int lat, output bit to);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    to = (out_valid !== 1'b1);
    cv = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (c !== 32'h0) begin
      miscompares++; $display("FAIL reset_c: got %h expected 00000000", c);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [14];
    logic [31:0] vb [14];
    logic [31:0] ve [14];
    logic [31:0] cv, ev;
    int lat;
    bit to;
    va = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F800000,
           32'h00000000, 32'h7F000000, 32'h00800000, 32'h7FC00001, 32'hFF800000,
           32'h3F800000, 32'h80400000, 32'hC0400000, 32'h3F800000};
    vb = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h7F800000,
           32'hC0000000, 32'h00800000, 32'h7F000000, 32'h3F800000, 32'h40000000,
           32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h00000001};
    ve = '{32'h40400000, 32'h3EAAAAAA, 32'hFF800000, 32'h7FC00000, 32'h7FC00000,
           32'h80000000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000,
           32'h00000000, 32'h80000000, 32'hC0400000, 32'h7F800000};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      send(va[i], vb[i], ve[i], to);
      vectors++;
      if (to) begin
        miscompares++; $display("FAIL directed_accept[%0d]: in_ready never high", i);
        continue;
      end
      wait_result(cv, lat, to);
      ev = pop_exp();
      vectors++;
      if (to || cv !== ev) begin
        miscompares++;
        $display("FAIL directed_c[%0d] %h/%h: got %h expected %h", i, va[i], vb[i], cv, ev);
      end
      vectors++;
      if (lat != 26) begin
        miscompares++; $display("FAIL directed_latency[%0d]: got %0d expected 26", i, lat);
      end
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL directed_drain[%0d]: out_valid %b in_ready %b expected 0/1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, cv, ev;
    int lat;
    bit to;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      x = {1'($urandom), 8'($urandom_range(254, 1)), 23'($urandom)};
      y = {1'($urandom), 8'($urandom_range(254, 1)), 23'($urandom)};
      send(x, y, model_div(x, y), to);
      if (to) begin
        vectors++; miscompares++; $display("FAIL random_accept[%0d]: in_ready never high", i);
        continue;
      end
      wait_result(cv, lat, to);
      ev = pop_exp();
      vectors++;
      if (to || cv !== ev) begin
        miscompares++;
        $display("FAIL random_c[%0d] %h/%h: got %h expected %h", i, x, y, cv, ev);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] cv, hold, ev;
    int lat;
    bit to;
    out_ready = 1'b0;
    send(32'h40C00000, 32'h40000000, 32'h40400000, to);
    wait_result(cv, lat, to);
    hold = cv;
    vectors++;
    if (to || lat != 26) begin
      miscompares++; $display("FAIL bp_latency: got %0d expected 26", lat);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 32'h3F800000; b = 32'h40400000;
      @(posedge clk); #1;
      vectors++;
      if (c !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: c %h out_valid %b in_ready %b expected %h/1/0",
                 i, c, out_valid, in_ready, hold);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    ev = pop_exp();
    vectors++;
    if (hold !== ev) begin
      miscompares++; $display("FAIL bp_c: got %h expected %h", hold, ev);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: out_valid %b in_ready %b expected 0/1", out_valid, in_ready);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL bp_no_accept: queue depth %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cv, ev;
    int lat;
    bit to;
    out_ready = 1'b1;
    send(32'h40C00000, 32'h40000000, 32'h40400000, to);
    wait_result(cv, lat, to);
    ev = pop_exp();
    vectors++;
    if (to || cv !== ev) begin
      miscompares++; $display("FAIL b2b_first: got %h expected %h", cv, ev);
    end
    // Operands offered while DONE hands off; acceptance must wait one cycle.
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h40400000;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_handoff: out_valid %b in_ready %b expected 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    exp_q.push_back(32'h3EAAAAAA);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL b2b_accept: in_ready %b expected 0", in_ready);
    end
    wait_result(cv, lat, to);
    ev = pop_exp();
    vectors++;
    if (to || cv !== ev || lat != 26) begin
      miscompares++;
      $display("FAIL b2b_second: got %h lat %0d expected %h lat 26", cv, lat, ev);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] cv, ev;
    int lat;
    bit to, seen;
    out_ready = 1'b1;
    send(32'h40C00000, 32'h40000000, 32'h40400000, to);
    repeat (12) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_state: in_ready %b out_valid %b c %h expected 1/0/00000000",
               in_ready, out_valid, c);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++; $display("FAIL midreset_no_output: got out_valid 1 expected 0");
    end
    send(32'h40C00000, 32'h40000000, 32'h40400000, to);
    wait_result(cv, lat, to);
    ev = pop_exp();
    vectors++;
    if (to || cv !== ev || lat != 26) begin
      miscompares++;
      $display("FAIL midreset_recover: got %h lat %0d expected %h lat 26", cv, lat, ev);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
